// File: rtl/lcd_byte_seq_if.sv
// Host byte handshake and SPI controller bus for lcd_byte_seq.
// master: the sequencer; slave: the host/SPI-controller side.
interface lcd_byte_seq_if;
  logic       in_valid;
  logic       in_dc;
  logic [7:0] in_data;
  logic       in_ready;
  logic       spi_send;
  logic [7:0] spi_data;
  logic       spi_done;
  logic       lcd_dc;

  modport master (
    input  in_valid, in_dc, in_data, spi_done,
    output in_ready, spi_send, spi_data, lcd_dc
  );

  modport slave (
    output in_valid, in_dc, in_data, spi_done,
    input  in_ready, spi_send, spi_data, lcd_dc
  );
endinterface

// File: rtl/lcd_byte_seq.sv
// LCD byte sequencer: hardware reset pulse, 4-entry init ROM, then host bytes to the SPI controller.
// Optional SEQ_TIMEOUT_EN: abandon a byte when spi_done does not complete within TIMEOUT_CYCLES.
module lcd_byte_seq #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  lcd_byte_seq_if.master bus,
  output logic           lcd_rst_n,
  output logic           init_done,
  output logic           busy,
  output logic           err_timeout
);

  typedef enum logic [2:0] {
    RST_LO, RST_HI, ROM_SEND, IDLE, HOST_SEND, WAIT_LO, WAIT_HI, GAP
  } state_t;

`ifdef SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  logic [15:0] cnt;
  logic [1:0]  rom_idx, rom_idx_d;
  logic        init_done_d;
  logic        byte_end, gap_end, timeout_hit, keep_cnt;
  logic [8:0]  rom_word;

  function automatic logic [8:0] rom_entry(input logic [1:0] idx);
    logic [8:0] e;
    case (idx)
      2'd0:    e = 9'h011;
      2'd1:    e = 9'h03A;
      2'd2:    e = 9'h155;
      default: e = 9'h029;
    endcase
    return e;
  endfunction

  always_comb begin
    state_d     = state;
    rom_idx_d   = rom_idx;
    init_done_d = init_done;
    byte_end    = 1'b0;
    gap_end     = 1'b0;
    timeout_hit = 1'b0;
    keep_cnt    = 1'b0;

    case (state)
      RST_LO:    if (cnt == RST_LAST) state_d = RST_HI;
      RST_HI:    if (cnt == RST_LAST) state_d = ROM_SEND;
      ROM_SEND:  state_d = WAIT_LO;
      IDLE:      if (bus.in_valid) state_d = HOST_SEND;
      HOST_SEND: state_d = WAIT_LO;
      WAIT_LO:   if (!bus.spi_done) state_d = WAIT_HI;
      WAIT_HI:   if (bus.spi_done) byte_end = 1'b1;
      GAP:       if (cnt == GAP_LAST) gap_end = 1'b1;
      default:   state_d = RST_LO;
    endcase

    // The timeout window spans WAIT_LO and WAIT_HI, so cnt must survive that hop.
    if (TIMEOUT_EN && (state == WAIT_LO || state == WAIT_HI) && cnt == TO_LAST &&
        !(state == WAIT_HI && bus.spi_done)) begin
      timeout_hit = 1'b1;
      byte_end    = 1'b1;
    end

    // A zero-length gap folds the post-gap decision into the WAIT_HI exit.
    if (byte_end) begin
      if (GAP_CYCLES == 0) gap_end = 1'b1;
      else                 state_d = GAP;
    end

    if (gap_end) begin
      if (!init_done) begin
        rom_idx_d = rom_idx + 2'd1;
        if (rom_idx == 2'd3) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = ROM_SEND;
        end
      end else begin
        state_d = IDLE;
      end
    end

    keep_cnt = TIMEOUT_EN && state == WAIT_LO && state_d == WAIT_HI;
    rom_word = rom_entry(rom_idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RST_LO;
      cnt          <= '0;
      rom_idx      <= '0;
      init_done    <= 1'b0;
      lcd_rst_n    <= 1'b0;
      busy         <= 1'b1;
      err_timeout  <= 1'b0;
      bus.spi_send <= 1'b0;
      bus.spi_data <= '0;
      bus.lcd_dc   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= (state_d != state && !keep_cnt) ? '0 : cnt + 16'd1;
      rom_idx      <= rom_idx_d;
      init_done    <= init_done_d;
      lcd_rst_n    <= (state_d != RST_LO);
      busy         <= (state_d != IDLE);
      err_timeout  <= timeout_hit;
      bus.spi_send <= (state_d == ROM_SEND) || (state_d == HOST_SEND);
      if (state_d == ROM_SEND) begin
        bus.lcd_dc   <= rom_word[8];
        bus.spi_data <= rom_word[7:0];
      end else if (state == IDLE && bus.in_valid) begin
        bus.lcd_dc   <= bus.in_dc;
        bus.spi_data <= bus.in_data;
      end
    end
  end

  assign bus.in_ready = (state == IDLE);

endmodule

// File: doc/lcd_byte_seq.md
Name: lcd_byte_seq

Overview:
- Upstream feeder for the SPI master controller in the SPI LCD path.
- After reset, pulses the LCD hardware reset, then plays a fixed 4-entry init command ROM.
- Afterwards, accepts host bytes through a valid/ready handshake and issues each one to the SPI controller as a one-cycle send pulse with a held data byte and D/C line.
- Tracks the controller's done level handshake, inserts a programmable inter-byte gap, and reports init completion and busy status.

Parameters:
RST_CYCLES, 16, cycles lcd_rst_n is held low, and also cycles waited after its release; legal range 1..65535
GAP_CYCLES, 2, idle cycles inserted after each completed byte before the next send; 0 allowed
TIMEOUT_CYCLES, 64, maximum cycles spent waiting on spi_done per byte (only with SEQ_TIMEOUT_EN); legal range 1..65535

Ports:
clk  in  1  system clock; SPI controller runs on same clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  host byte valid
in_dc  in  1  host D/C flag: 0 = command, 1 = data
in_data  in  8  host byte
in_ready  out  1  high when the block accepts a host byte this cycle
spi_send  out  1  one-cycle request to SPI controller
spi_data  out  8  byte presented to the SPI shift register; held from send until byte complete
spi_done  in  1  SPI controller done level; high in its Done state, low in Load/Wait/Shift/Init
lcd_dc  out  1  LCD D/C pin; held with spi_data
lcd_rst_n  out  1  LCD hardware reset, active-low
init_done  out  1  sticky high once init ROM is fully sent
busy  out  1  high in any state other than IDLE
err_timeout  out  1  one-cycle pulse on spi_done timeout; constant 0 without SEQ_TIMEOUT_EN

Behaviour:
- All registers are reset asynchronously.
- Reset values: state RST_LO, lcd_rst_n=0, spi_send=0, spi_data=0x00, lcd_dc=0, in_ready=0, init_done=0, busy=1, err_timeout=0, counter=0, rom_idx=0.
- Outputs are registered. The only exception is in_ready, which is combinational: (state==IDLE).
- Single 16-bit counter cnt; reloads to 0 on every state entry.
- States and transitions:
  - RST_LO: lcd_rst_n=0. When cnt==RST_CYCLES-1 -> RST_HI.
  - RST_HI: lcd_rst_n=1. When cnt==RST_CYCLES-1 -> ROM_SEND.
  - ROM_SEND: load {lcd_dc,spi_data} from ROM[rom_idx], spi_send=1 for exactly this one cycle, then -> WAIT_LO.
    - ROM contents (dc,byte): 0:(0,0x11) 1:(0,0x3A) 2:(1,0x55) 3:(0,0x29).
  - IDLE: in_ready=1. On in_valid: latch {in_dc,in_data} into {lcd_dc,spi_data}, spi_send=1 the next cycle (HOST_SEND), then -> WAIT_LO.
    - Exactly one host byte is accepted per handshake.
  - WAIT_LO: wait for spi_done==0, which confirms the controller left Done/Init and loaded the byte, then -> WAIT_HI.
    - spi_done already low at entry (first byte after reset) satisfies this the same cycle.
  - WAIT_HI: wait for spi_done==1 -> GAP.
  - GAP: hold for GAP_CYCLES cycles (GAP_CYCLES==0: zero-cycle pass-through), then:
    - if init_done==0: rom_idx++; if rom_idx was 3, set init_done=1 and -> IDLE; else -> ROM_SEND.
    - if init_done==1: -> IDLE.
- spi_data and lcd_dc change only on ROM_SEND/IDLE acceptance; they are stable through WAIT_LO/WAIT_HI/GAP.
- spi_send is never high in two consecutive cycles and never high outside ROM_SEND/HOST_SEND.
- in_ready stays low during reset, init, and any in-flight byte; in_valid while not ready is ignored (host must hold).
- spi_done glitch behaviour: a low->high transition only counts after WAIT_LO has been satisfied. A done level that is already high when a send is issued must not complete the byte.
- rst asserted mid-operation returns to RST_LO immediately and re-runs LCD reset and the full init ROM. init_done clears.
- Latency: host byte accepted at cycle N -> spi_send high at N+1. With GAP_CYCLES=2, in_ready returns 3 cycles after spi_done rises (1 cycle WAIT_HI exit + 2 gap).

Optional Feature:
SEQ_TIMEOUT_EN
- Defined:
  - cnt runs across WAIT_LO+WAIT_HI for each byte.
  - When cnt reaches TIMEOUT_CYCLES without WAIT_HI completing, err_timeout pulses for 1 cycle and the byte is abandoned: -> GAP.
  - The ROM index still advances, so init continues.
- Not defined: no timeout logic; WAIT_LO/WAIT_HI wait indefinitely; err_timeout tied to 0.

Test Plan:
- Reset release, RST_CYCLES=16 -> lcd_rst_n low 16 cycles, high-wait 16 cycles, then 4 spi_send pulses with (dc,data)=(0,11),(0,3A),(1,55),(0,29) in order, each only after the model controller's done rises; init_done=1 after the 4th gap.
- After init, host sends in_valid with dc=1, data=0xA5 held one cycle -> in_ready drops next cycle, spi_send single pulse, spi_data=0xA5 and lcd_dc=1 stable until done; in_ready returns GAP_CYCLES+1 cycles after done rises.
- Controller model holding done=1 from a previous byte when a send is issued -> block stays in WAIT_LO until done falls; no early completion.
- Back-to-back host bytes 0x01,0x02,0x03 with in_valid held high -> exactly 3 sends in order, no duplicates, gap ≥2 cycles between done and next send.
- rst asserted during Shift of ROM byte 2 -> all outputs at reset values asynchronously; after release, full init sequence restarts from 0x11.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, controller never raises done -> err_timeout pulse at cycle 64 after the send; sequence proceeds to the next ROM byte; without the macro, the block stays in WAIT_HI and err_timeout=0.
